// File: rtl/program_sequencer.sv
// program_sequencer: loadable program store that issues one word at a time
// to the processor, pulsing run and waiting for done under a watchdog.
module program_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic [AW:0]      prog_len,
  input  logic             done,
  output logic [WIDTH-1:0] DIN,
  output logic             run,
  output logic [AW-1:0]    pc,
  output logic             busy,
  output logic             halted,
  output logic             error
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]    DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0]  WD_MAX  = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERR
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      len_r;
  logic [WW-1:0]    wd;
  logic [AW-1:0]    pc_nxt;
  logic             last;

  assign pc_nxt = pc + AW'(1);
  assign last   = ({1'b0, pc} == (len_r - (AW + 1)'(1)));

  // Program store survives reset; loads are locked out while executing.
  always_ff @(posedge clk_50MHz) begin
    if (load_en && !busy)
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state  <= S_IDLE;
      DIN    <= '0;
      run    <= 1'b0;
      pc     <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
      error  <= 1'b0;
      len_r  <= '0;
      wd     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT, S_ERR: begin
          if (start) begin
            halted <= 1'b0;
            error  <= 1'b0;
            if (prog_len == '0) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state <= S_ISSUE;
              pc    <= '0;
              DIN   <= mem[0];
              run   <= 1'b1;
              busy  <= 1'b1;
              len_r <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
            end
          end
        end
        S_ISSUE: begin
          run   <= 1'b0;
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over a watchdog expiring on the same edge
          if (done) begin
            if (last) begin
              state  <= S_HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
            end else begin
              state <= S_ISSUE;
              pc    <= pc_nxt;
              DIN   <= mem[pc_nxt];
              run   <= 1'b1;
            end
          end else if (wd == WD_MAX) begin
            state <= S_ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          run   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed vectors for program_sequencer with
// hand-computed expectations.
module tb_program_sequencer;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic [5:0]  prog_len;
  logic        done;
  logic [15:0] DIN;
  logic        run;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
  logic        error;

  int total;
  int bad;

  program_sequencer dut (
    .clk_50MHz (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .prog_len  (prog_len),
    .done      (done),
    .DIN       (DIN),
    .run       (run),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .error     (error)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick;
    load_en   = 1'b0;
  endtask

  task automatic go(input logic [5:0] n);
    prog_len = n;
    start    = 1'b1;
    tick;
    start    = 1'b0;
  endtask

  task automatic serve(input int d);
    repeat (d) tick;
    done = 1'b1;
    tick;
    done = 1'b0;
  endtask

  initial begin
    int pulses;
    int consec;
    int seen;
    logic prev;
    logic [15:0] last_din;

    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    start     = 1'b0;
    prog_len  = '0;
    done      = 1'b0;

    tick;
    tick;
    check("rst_run", run, 0);
    check("rst_din", DIN, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_halt", halted, 0);
    check("rst_err", error, 0);
    reset = 1'b0;

    // 1: three-word program, done 3 cycles after each run
    load(5'd0, 16'hA000);
    load(5'd1, 16'hB111);
    load(5'd2, 16'hC222);
    load(5'd3, 16'hD333);
    go(6'd3);
    check("t1_run0", run, 1);
    check("t1_din0", DIN, 16'hA000);
    check("t1_pc0", pc, 0);
    check("t1_busy", busy, 1);
    tick;
    check("t1_run_lo", run, 0);
    serve(2);
    check("t1_run1", run, 1);
    check("t1_din1", DIN, 16'hB111);
    check("t1_pc1", pc, 1);
    serve(3);
    check("t1_din2", DIN, 16'hC222);
    check("t1_pc2", pc, 2);
    serve(3);
    check("t1_halt", halted, 1);
    check("t1_idle", busy, 0);
    check("t1_norun", run, 0);

    // 2: empty program halts immediately
    reset = 1'b1;
    tick;
    reset = 1'b0;
    go(6'd0);
    check("t2_halt", halted, 1);
    check("t2_busy", busy, 0);
    seen = int'(run);
    repeat (4) begin
      tick;
      seen |= int'(run);
    end
    check("t2_norun", seen, 0);

    // 3: watchdog expiry, restart, then done on the expiry edge
    go(6'd1);
    check("t3_run", run, 1);
    tick;
    repeat (63) tick;
    check("t3_err_early", error, 0);
    check("t3_busy", busy, 1);
    tick;
    check("t3_err", error, 1);
    check("t3_err_busy", busy, 0);
    check("t3_err_halt", halted, 0);
    go(6'd1);
    check("t3_rerun", run, 1);
    check("t3_rerun_pc", pc, 0);
    check("t3_err_clr", error, 0);
    check("t3_rerun_din", DIN, 16'hA000);
    tick;
    repeat (63) tick;
    done = 1'b1;
    tick;
    done = 1'b0;
    check("t3_done_wins", halted, 1);
    check("t3_no_err", error, 0);

    // 4: done tied high, four instructions
    done = 1'b1;
    go(6'd4);
    pulses   = int'(run);
    prev     = run;
    consec   = 0;
    last_din = DIN;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (run && prev) consec = 1;
      if (run) begin
        pulses++;
        last_din = DIN;
      end
      prev = run;
    end
    done = 1'b0;
    check("t4_pulses", pulses, 4);
    check("t4_spacing", consec, 0);
    check("t4_last_din", last_din, 16'hD333);
    check("t4_halt", halted, 1);

    // 5: load during busy is dropped
    go(6'd3);
    check("t5_din0", DIN, 16'hA000);
    load_en   = 1'b1;
    load_addr = 5'd1;
    load_data = 16'hFFFF;
    tick;
    tick;
    load_en = 1'b0;
    done    = 1'b1;
    tick;
    done    = 1'b0;
    check("t5_din1", DIN, 16'hB111);
    serve(1);
    check("t5_din2", DIN, 16'hC222);
    serve(1);
    check("t5_halt", halted, 1);
    go(6'd2);
    serve(1);
    check("t5_kept", DIN, 16'hB111);
    serve(1);

    // 6: reset mid-program, then rerun
    go(6'd4);
    serve(1);
    serve(1);
    tick;
    check("t6_pc2", pc, 2);
    check("t6_busy", busy, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("t6_run", run, 0);
    check("t6_din", DIN, 0);
    check("t6_pc", pc, 0);
    check("t6_busy0", busy, 0);
    check("t6_halt", halted, 0);
    check("t6_err", error, 0);
    go(6'd4);
    check("t6_din0", DIN, 16'hA000);
    serve(1);
    check("t6_din1", DIN, 16'hB111);
    serve(1);
    check("t6_din2", DIN, 16'hC222);
    serve(1);
    check("t6_din3", DIN, 16'hD333);
    serve(1);
    check("t6_done", halted, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
